// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths and a constant log2 helper
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NUM_GPR = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/gpr_file_if.sv
// gpr_file_if: decode/writeback bus of the register file
interface gpr_file_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(DEPTH);
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*WIDTH-1:0] rdata;
  logic [NREAD-1:0]       rbusy;
  logic                   we0, we1;
  logic [AW-1:0]          waddr0, waddr1;
  logic [WIDTH-1:0]       wdata0, wdata1;
  logic                   reserve;
  logic [AW-1:0]          res_addr;
  logic [AW:0]            busy_count;
  modport master (
    output raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, reserve, res_addr,
    input  rdata, rbusy, busy_count
  );
  modport slave (
    input  raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, reserve, res_addr,
    output rdata, rbusy, busy_count
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register pending-write bits with an incremental busy count
module gpr_scoreboard #(
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr0,
  input  logic [AW-1:0]       i_clr_addr0,
  input  logic                i_clr1,
  input  logic [AW-1:0]       i_clr_addr1,
  input  logic                i_set,
  input  logic [AW-1:0]       i_set_addr,
  input  logic [NREAD*AW-1:0] i_look_addr,
  output logic [NREAD-1:0]    o_look_busy,
  output logic [AW:0]         o_count
);
  logic [DEPTH-1:0] r_busy, w_busy_nx;
  logic [AW:0]      r_count;
  logic             w_set, w_inc, w_dec0, w_dec1;
  assign w_set  = i_set && !(ZERO_REG != 0 && i_set_addr == '0);
  assign w_inc  = w_set && !r_busy[i_set_addr];
  // a clear only counts when the reservation does not re-set it and lane 0 has not already cleared it
  assign w_dec0 = i_clr0 && r_busy[i_clr_addr0] && !(w_set && i_set_addr == i_clr_addr0);
  assign w_dec1 = i_clr1 && r_busy[i_clr_addr1] && !(w_set && i_set_addr == i_clr_addr1)
                  && !(i_clr0 && i_clr_addr0 == i_clr_addr1);
  always_comb begin
    w_busy_nx = r_busy;
    if (i_clr0) w_busy_nx[i_clr_addr0] = 1'b0;
    if (i_clr1) w_busy_nx[i_clr_addr1] = 1'b0;
    if (w_set) w_busy_nx[i_set_addr] = 1'b1;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nx;
      r_count <= r_count + (AW+1)'(w_inc) - (AW+1)'(w_dec0) - (AW+1)'(w_dec1);
    end
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_look
    assign o_look_busy[k] = r_busy[i_look_addr[k*AW +: AW]];
  end
  assign o_count = r_count;
endmodule

// File: rtl/gpr_file.sv
// gpr_file: dual-write, multi-read register file with optional zero register,
// write-to-read bypass and a pending-write scoreboard
module gpr_file
  import cpu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = NUM_GPR,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic       i_clk,
  input logic       i_rst,
  gpr_file_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             w_we0, w_we1;
  logic [NREAD-1:0] w_look_busy;
  assign w_we0 = bus.we0 && !(ZERO_REG != 0 && bus.waddr0 == '0);
  assign w_we1 = bus.we1 && !(ZERO_REG != 0 && bus.waddr1 == '0);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (w_we0) r_regs[bus.waddr0] <= bus.wdata0;
      if (w_we1) r_regs[bus.waddr1] <= bus.wdata1;
    end
  end
  gpr_scoreboard #(.DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(ZERO_REG)) u_sb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr0      (bus.we0),
    .i_clr_addr0 (bus.waddr0),
    .i_clr1      (bus.we1),
    .i_clr_addr1 (bus.waddr1),
    .i_set       (bus.reserve),
    .i_set_addr  (bus.res_addr),
    .i_look_addr (bus.raddr),
    .o_look_busy (w_look_busy),
    .o_count     (bus.busy_count)
  );
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero, w_hit0, w_hit1;
    assign w_ra   = bus.raddr[k*AW +: AW];
    assign w_zero = ZERO_REG != 0 && w_ra == '0;
    assign w_hit0 = BYPASS != 0 && bus.we0 && bus.waddr0 == w_ra;
    assign w_hit1 = BYPASS != 0 && bus.we1 && bus.waddr1 == w_ra;
    // lane 1 is the younger retire, so it shadows lane 0 on the bypass path too
    assign bus.rdata[k*WIDTH +: WIDTH] = w_zero ? '0 : w_hit1 ? bus.wdata1 : w_hit0 ? bus.wdata0 : r_regs[w_ra];
    assign bus.rbusy[k] = !w_zero && w_look_busy[k] && !(w_hit0 || w_hit1);
  end
endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed checks plus a per-cycle model comparison for two configurations
module tb_gpr_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gpr_file_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus_a ();
  gpr_file_if #(.WIDTH(16), .DEPTH(8), .NREAD(3)) bus_b ();
  gpr_file #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a));
  gpr_file #(.WIDTH(16), .DEPTH(8), .NREAD(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b));
  logic [31:0] ma_regs [32];
  bit          ma_busy [32];
  logic [15:0] mb_regs [8];
  bit          mb_busy [8];
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ea_data(input logic [4:0] ra);
    if (ra == 0) return 0;
    if (bus_a.we1 && bus_a.waddr1 == ra) return bus_a.wdata1;
    if (bus_a.we0 && bus_a.waddr0 == ra) return bus_a.wdata0;
    return ma_regs[ra];
  endfunction
  function automatic logic ea_busy(input logic [4:0] ra);
    return ra != 0 && ma_busy[ra] && !((bus_a.we0 && bus_a.waddr0 == ra) || (bus_a.we1 && bus_a.waddr1 == ra));
  endfunction
  function automatic int pop_a();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(ma_busy[i]);
    return c;
  endfunction
  function automatic int pop_b();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(mb_busy[i]);
    return c;
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin ma_regs[i] = 0; ma_busy[i] = 0; end
    for (int i = 0; i < 8; i++) begin mb_regs[i] = 0; mb_busy[i] = 0; end
  endtask
  task automatic model_edge();
    if (rst) begin
      clear_model();
      return;
    end
    if (bus_a.we0 && bus_a.waddr0 != 0) ma_regs[bus_a.waddr0] = bus_a.wdata0;
    if (bus_a.we1 && bus_a.waddr1 != 0) ma_regs[bus_a.waddr1] = bus_a.wdata1;
    if (bus_a.we0) ma_busy[bus_a.waddr0] = 0;
    if (bus_a.we1) ma_busy[bus_a.waddr1] = 0;
    if (bus_a.reserve && bus_a.res_addr != 0) ma_busy[bus_a.res_addr] = 1;
    if (bus_b.we0 && bus_b.waddr0 != 0) mb_regs[bus_b.waddr0] = bus_b.wdata0;
    if (bus_b.we1 && bus_b.waddr1 != 0) mb_regs[bus_b.waddr1] = bus_b.wdata1;
    if (bus_b.we0) mb_busy[bus_b.waddr0] = 0;
    if (bus_b.we1) mb_busy[bus_b.waddr1] = 0;
    if (bus_b.reserve && bus_b.res_addr != 0) mb_busy[bus_b.res_addr] = 1;
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic wa(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                    input logic r, input logic [4:0] ra);
    bus_a.we0 = e0; bus_a.waddr0 = a0; bus_a.wdata0 = d0;
    bus_a.we1 = e1; bus_a.waddr1 = a1; bus_a.wdata1 = d1;
    bus_a.reserve = r; bus_a.res_addr = ra;
  endtask
  task automatic wb(input logic e0, input logic [2:0] a0, input logic [15:0] d0,
                    input logic e1, input logic [2:0] a1, input logic [15:0] d1,
                    input logic r, input logic [2:0] ra);
    bus_b.we0 = e0; bus_b.waddr0 = a0; bus_b.wdata0 = d0;
    bus_b.we1 = e1; bus_b.waddr1 = a1; bus_b.wdata1 = d1;
    bus_b.reserve = r; bus_b.res_addr = ra;
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("a_rdata", bus_a.rdata[k*32 +: 32], ea_data(bus_a.raddr[k*5 +: 5]));
      chk("a_rbusy", bus_a.rbusy[k], ea_busy(bus_a.raddr[k*5 +: 5]));
    end
    chk("a_count", bus_a.busy_count, pop_a());
    for (int k = 0; k < 3; k++) begin
      chk("b_rdata", bus_b.rdata[k*16 +: 16], bus_b.raddr[k*3 +: 3] == 0 ? 16'h0 : mb_regs[bus_b.raddr[k*3 +: 3]]);
      chk("b_rbusy", bus_b.rbusy[k], bus_b.raddr[k*3 +: 3] != 0 && mb_busy[bus_b.raddr[k*3 +: 3]]);
    end
    chk("b_count", bus_b.busy_count, pop_b());
  end
  initial begin
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0, 0, 0, 0, 0);
    bus_a.raddr = '0;
    bus_b.raddr = '0;
    clear_model();
    #12 rst = 1'b0;
    tick();
    // reset mid-cycle clears data and scoreboard at once
    wa(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 8);
    tick();
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    bus_a.raddr = {5'd8, 5'd5};
    #1;
    chk("pre_rst_r5", bus_a.rdata[31:0], 32'hDEADBEEF);
    chk("pre_rst_busy8", bus_a.rbusy[1], 1'b1);
    chk("pre_rst_count", bus_a.busy_count, 1);
    #1 rst = 1'b1;
    clear_model();
    #1;
    chk("rst_r5", bus_a.rdata[31:0], 32'h0);
    chk("rst_count", bus_a.busy_count, 0);
    chk("rst_busy8", bus_a.rbusy[1], 1'b0);
    #3 rst = 1'b0;
    tick();
    // dual write to the same register: lane 1 wins
    wa(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0);
    bus_a.raddr = {5'd0, 5'd7};
    #1 chk("dual_bypass", bus_a.rdata[31:0], 32'h22222222);
    tick();
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("dual_held", bus_a.rdata[31:0], 32'h22222222);
    // register 0 stays zero and never busy
    wa(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    bus_a.raddr = '0;
    #1 chk("zero_bypass", bus_a.rdata[31:0], 32'h0);
    tick();
    wa(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("zero_data", bus_a.rdata[31:0], 32'h0);
    chk("zero_busy", bus_a.rbusy[0], 1'b0);
    chk("zero_count", bus_a.busy_count, 0);
    // scoreboard flow
    wa(0, 0, 0, 0, 0, 0, 1, 3);
    tick();
    #1 chk("sb_count1", bus_a.busy_count, 1);
    wa(0, 0, 0, 0, 0, 0, 1, 4);
    tick();
    #1 chk("sb_count2", bus_a.busy_count, 2);
    wa(1, 3, 32'h00000033, 0, 0, 0, 1, 9);
    bus_a.raddr = {5'd9, 5'd3};
    #1 chk("sb_r3_bypass_busy", bus_a.rbusy[0], 1'b0);
    tick();
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sb_count_after", bus_a.busy_count, 2);
    chk("sb_r9_busy", bus_a.rbusy[1], 1'b1);
    chk("sb_r3_data", bus_a.rdata[31:0], 32'h00000033);
    // reservation beats a same-edge write to the same register
    wa(0, 0, 0, 0, 0, 0, 1, 6);
    tick();
    #1 chk("col_count_pre", bus_a.busy_count, 3);
    wa(0, 0, 0, 1, 6, 32'hCAFE0000, 1, 6);
    tick();
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    bus_a.raddr = {5'd0, 5'd6};
    #1;
    chk("col_data", bus_a.rdata[31:0], 32'hCAFE0000);
    chk("col_busy", bus_a.rbusy[0], 1'b1);
    chk("col_count", bus_a.busy_count, 3);
    // two retires clearing two busy registers in one edge
    wa(1, 4, 32'h44, 1, 9, 32'h99, 0, 0);
    tick();
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("dbl_clear_count", bus_a.busy_count, 1);
    // narrow configuration without bypass: data appears only after the edge
    wb(1, 2, 16'h1234, 0, 0, 0, 0, 0);
    bus_b.raddr = {3'd2, 3'd2, 3'd2};
    #1;
    for (int k = 0; k < 3; k++) chk("b_no_bypass", bus_b.rdata[k*16 +: 16], 16'h0);
    tick();
    wb(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 3; k++) chk("b_after_write", bus_b.rdata[k*16 +: 16], 16'h1234);
    // mixed traffic on a small address range to provoke collisions
    for (int n = 0; n < 300; n++) begin
      wa(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
         1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
         1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      bus_a.raddr = 10'($urandom);
      bus_b.raddr = 9'($urandom);
      tick();
    end
    wa(0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
